maj127_voter: RTL and testbench
===============================

Name: maj127_voter

Overview:
Registered 127-input majority voter.
- Each clock edge it samples 127 single-bit inputs, counts the ones, and registers y0 = 1 when the count is at least 64.
- Used as the majority/threshold leaf in the folded bias-decomposition datapath.
- Holds no other state beyond the output register.

Parameters:
None exposed. Internal localparams:
- N_IN = 127: number of inputs.
- MAJ_THR = 64: ones count at or above which y0 = 1, i.e. (N_IN+1)/2.
- CNT_W = 7: popcount width, covering 0..127.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- x0 .. x126  input  1 each  voter inputs; 127 scalar ports named x0 through x126, all equal weight
- y0  output  1  registered majority result

Behaviour:
- Reset: rst high forces y0 = 0 immediately, with no clock needed. It holds 0 while rst is high.
- Reset release: the first rising clk edge after rst falls loads a valid result.
- Function: cnt = x0 + x1 + ... + x126, a 7-bit unsigned value with no overflow (maximum 127). maj = (cnt >= 64).
- Latency: exactly 1 cycle. Inputs present before rising edge k appear on y0 after edge k. There is no input register, so total path = one adder tree + one flop.
- Throughput: one new vector per cycle. No handshake and no enable.
- Symmetry: y0 depends only on the count of ones, never on which inputs are set.
- Boundary values:
  - cnt = 63 → 0
  - cnt = 64 → 1
  - cnt = 0 → 0
  - cnt = 127 → 1
  - A tie is impossible because N_IN is odd.
- Reset mid-operation: y0 drops to 0 asynchronously. The in-flight result is discarded.
- X handling: no requirement. Inputs are assumed to be driven once reset is released.
- Implementation: the count is built with a carry-save tree of full adders (3:2 compressors) reducing to a 7-bit sum, followed by the >= 64 compare. Because MAJ_THR = 64, the compare equals cnt[6]; the full tree is still built so the threshold localparam stays meaningful.
- Timing: combinational depth ≤ about 12 full-adder levels plus the final adder.

Decomposition:
- Shared package maj_pkg holds N_IN, MAJ_THR and CNT_W.
- One natural sub-module, fa_cell: a 1-bit full adder (a, b, cin → s, cout). The top instantiates fa_cell in a generate-built CSA tree, plus a small ripple adder for the final 7-bit sum.
- The output flop lives in maj127_voter.

Test Plan:
- Assert rst with all inputs = 1 → y0 = 0 at once and stays 0 across clocks. Release rst and clock once → y0 = 1.
- All zeros, then all ones, on consecutive cycles → y0 = 0 after the first edge, then 1 after the next edge. This confirms 1-cycle latency.
- Threshold edge: x0..x62 = 1 (63 ones) → y0 = 0. Add x63 (64 ones) → y0 = 1. Remove x0 (63 ones) → y0 = 0.
- Position independence: 64 ones placed on x63..x126, then on even indices x0..x126 (64 ones), then 63 random positions → 1, 1, 0.
- Async reset mid-stream: while driving 100 ones and y0 = 1, pulse rst between edges → y0 goes to 0 before the next edge and recovers to 1 one edge after release.
- Random sweep: at least 10k random vectors, with popcount biased toward 60..68, compared against a behavioural reference (popcount >= 64) delayed by one cycle → zero mismatches.

Source files
------------

// File: rtl/maj_pkg.sv
// Shared constants for the 127-input majority voter and its carry-save count tree.
package maj_pkg;

   localparam int N_IN    = 127;
   localparam int MAJ_THR = 64;
   localparam int CNT_W   = 7;

   // The count is built as two 63-input trees plus x126 as the final carry-in.
   localparam int HALF_N  = 63;
   localparam int HALF_W  = 6;

   // Bits entering column c of a 63-input tree (63, 31, 15, 7, 3).
   function automatic int col_size(input int c);
      return (1 << (HALF_W - c)) - 1;
   endfunction

   function automatic int col_fa(input int c);
      return (col_size(c) - 1) / 2;
   endfunction

   // Base index of column c's carries inside the per-tree carry bus.
   function automatic int carry_off(input int c);
      int off;
      off = 0;
      for (int j = 0; j < c; j++) begin
         off += col_fa(j);
      end
      return off;
   endfunction

endpackage

// File: rtl/maj127_voter_fa_cell.sv
// 1-bit full adder; the 3:2 compressor used by the count tree and the final ripple adder.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/maj127_voter.sv
// Registered 127-input majority voter: carry-save popcount, >= MAJ_THR compare, one output flop.
module maj127_voter
   import maj_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic x0,   x1,   x2,   x3,   x4,   x5,   x6,   x7,
   input  logic x8,   x9,   x10,  x11,  x12,  x13,  x14,  x15,
   input  logic x16,  x17,  x18,  x19,  x20,  x21,  x22,  x23,
   input  logic x24,  x25,  x26,  x27,  x28,  x29,  x30,  x31,
   input  logic x32,  x33,  x34,  x35,  x36,  x37,  x38,  x39,
   input  logic x40,  x41,  x42,  x43,  x44,  x45,  x46,  x47,
   input  logic x48,  x49,  x50,  x51,  x52,  x53,  x54,  x55,
   input  logic x56,  x57,  x58,  x59,  x60,  x61,  x62,  x63,
   input  logic x64,  x65,  x66,  x67,  x68,  x69,  x70,  x71,
   input  logic x72,  x73,  x74,  x75,  x76,  x77,  x78,  x79,
   input  logic x80,  x81,  x82,  x83,  x84,  x85,  x86,  x87,
   input  logic x88,  x89,  x90,  x91,  x92,  x93,  x94,  x95,
   input  logic x96,  x97,  x98,  x99,  x100, x101, x102, x103,
   input  logic x104, x105, x106, x107, x108, x109, x110, x111,
   input  logic x112, x113, x114, x115, x116, x117, x118, x119,
   input  logic x120, x121, x122, x123, x124, x125, x126,
   output logic y0
);

   logic [N_IN-1:0]             xv;
   logic [1:0][HALF_W-1:0]      half_cnt;
   logic [HALF_W:0]             rc;
   logic [CNT_W-1:0]            cnt;
   logic                        maj;

   assign xv = {x126, x125, x124, x123, x122, x121, x120,
                x119, x118, x117, x116, x115, x114, x113, x112,
                x111, x110, x109, x108, x107, x106, x105, x104,
                x103, x102, x101, x100, x99,  x98,  x97,  x96,
                x95,  x94,  x93,  x92,  x91,  x90,  x89,  x88,
                x87,  x86,  x85,  x84,  x83,  x82,  x81,  x80,
                x79,  x78,  x77,  x76,  x75,  x74,  x73,  x72,
                x71,  x70,  x69,  x68,  x67,  x66,  x65,  x64,
                x63,  x62,  x61,  x60,  x59,  x58,  x57,  x56,
                x55,  x54,  x53,  x52,  x51,  x50,  x49,  x48,
                x47,  x46,  x45,  x44,  x43,  x42,  x41,  x40,
                x39,  x38,  x37,  x36,  x35,  x34,  x33,  x32,
                x31,  x30,  x29,  x28,  x27,  x26,  x25,  x24,
                x23,  x22,  x21,  x20,  x19,  x18,  x17,  x16,
                x15,  x14,  x13,  x12,  x11,  x10,  x9,   x8,
                x7,   x6,   x5,   x4,   x3,   x2,   x1,   x0};

   // Each column is a FIFO of bits: full adder k consumes entries 3k..3k+2 and appends
   // its sum at NC+k, which gives a balanced tree and leaves one sum bit per column.
   for (genvar h = 0; h < 2; h++) begin : g_half
      logic [carry_off(HALF_W-1)-1:0] carry;

      for (genvar c = 0; c < HALF_W - 1; c++) begin : g_col
         localparam int NC = col_size(c);
         localparam int FC = col_fa(c);
         logic [NC+FC-1:0] q;

         if (c == 0) begin : g_leaf
            assign q[NC-1:0] = xv[h*HALF_N +: HALF_N];
         end else begin : g_link
            assign q[NC-1:0] = carry[carry_off(c-1) +: NC];
         end

         for (genvar k = 0; k < FC; k++) begin : g_fa
            fa_cell u_fa (
               .a    (q[3*k]),
               .b    (q[3*k+1]),
               .cin  (q[3*k+2]),
               .s    (q[NC+k]),
               .cout (carry[carry_off(c)+k])
            );
         end

         assign half_cnt[h][c] = q[NC+FC-1];
      end

      assign half_cnt[h][HALF_W-1] = carry[carry_off(HALF_W-1)-1];
   end

   // x126 rides in as the carry-in, so the two 63-input counts sum to the full 0..127 range.
   assign rc[0] = xv[N_IN-1];

   for (genvar i = 0; i < HALF_W; i++) begin : g_rca
      fa_cell u_fa (
         .a    (half_cnt[0][i]),
         .b    (half_cnt[1][i]),
         .cin  (rc[i]),
         .s    (cnt[i]),
         .cout (rc[i+1])
      );
   end

   assign cnt[CNT_W-1] = rc[HALF_W];
   assign maj          = (cnt >= CNT_W'(MAJ_THR));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y0 <= 1'b0;
      end else begin
         y0 <= maj;
      end
   end

endmodule

// File: tb/tb_maj127_voter.sv
// Scoreboard bench for maj127_voter: expected majority pushed at drive time, popped after the edge.
module tb_maj127_voter;

   logic         clk;
   logic         rst;
   logic [126:0] x;
   logic         y0;

   int n_vec;
   int n_err;
   logic exp_q [$];

   maj127_voter dut (
      .clk(clk), .rst(rst),
      .x0(x[0]),     .x1(x[1]),     .x2(x[2]),     .x3(x[3]),     .x4(x[4]),     .x5(x[5]),     .x6(x[6]),     .x7(x[7]),
      .x8(x[8]),     .x9(x[9]),     .x10(x[10]),   .x11(x[11]),   .x12(x[12]),   .x13(x[13]),   .x14(x[14]),   .x15(x[15]),
      .x16(x[16]),   .x17(x[17]),   .x18(x[18]),   .x19(x[19]),   .x20(x[20]),   .x21(x[21]),   .x22(x[22]),   .x23(x[23]),
      .x24(x[24]),   .x25(x[25]),   .x26(x[26]),   .x27(x[27]),   .x28(x[28]),   .x29(x[29]),   .x30(x[30]),   .x31(x[31]),
      .x32(x[32]),   .x33(x[33]),   .x34(x[34]),   .x35(x[35]),   .x36(x[36]),   .x37(x[37]),   .x38(x[38]),   .x39(x[39]),
      .x40(x[40]),   .x41(x[41]),   .x42(x[42]),   .x43(x[43]),   .x44(x[44]),   .x45(x[45]),   .x46(x[46]),   .x47(x[47]),
      .x48(x[48]),   .x49(x[49]),   .x50(x[50]),   .x51(x[51]),   .x52(x[52]),   .x53(x[53]),   .x54(x[54]),   .x55(x[55]),
      .x56(x[56]),   .x57(x[57]),   .x58(x[58]),   .x59(x[59]),   .x60(x[60]),   .x61(x[61]),   .x62(x[62]),   .x63(x[63]),
      .x64(x[64]),   .x65(x[65]),   .x66(x[66]),   .x67(x[67]),   .x68(x[68]),   .x69(x[69]),   .x70(x[70]),   .x71(x[71]),
      .x72(x[72]),   .x73(x[73]),   .x74(x[74]),   .x75(x[75]),   .x76(x[76]),   .x77(x[77]),   .x78(x[78]),   .x79(x[79]),
      .x80(x[80]),   .x81(x[81]),   .x82(x[82]),   .x83(x[83]),   .x84(x[84]),   .x85(x[85]),   .x86(x[86]),   .x87(x[87]),
      .x88(x[88]),   .x89(x[89]),   .x90(x[90]),   .x91(x[91]),   .x92(x[92]),   .x93(x[93]),   .x94(x[94]),   .x95(x[95]),
      .x96(x[96]),   .x97(x[97]),   .x98(x[98]),   .x99(x[99]),   .x100(x[100]), .x101(x[101]), .x102(x[102]), .x103(x[103]),
      .x104(x[104]), .x105(x[105]), .x106(x[106]), .x107(x[107]), .x108(x[108]), .x109(x[109]), .x110(x[110]), .x111(x[111]),
      .x112(x[112]), .x113(x[113]), .x114(x[114]), .x115(x[115]), .x116(x[116]), .x117(x[117]), .x118(x[118]), .x119(x[119]),
      .x120(x[120]), .x121(x[121]), .x122(x[122]), .x123(x[123]), .x124(x[124]), .x125(x[125]), .x126(x[126]),
      .y0(y0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic got, input logic exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: y0=%b expected %b", tag, got, exp);
      end
   endtask

   // Drive a vector just after an edge, score it one edge later.
   task automatic apply(input string tag, input logic [126:0] v);
      logic e;
      x = v;
      exp_q.push_back($countones(v) >= 64);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk(tag, y0, e);
   endtask

   function automatic logic [126:0] rand_vec(input int k);
      logic [126:0] v;
      v = '0;
      while ($countones(v) < k) v[$urandom_range(126, 0)] = 1'b1;
      return v;
   endfunction

   initial begin
      logic [126:0] v;
      int k;
      n_vec = 0;
      n_err = 0;
      rst   = 1'b0;
      x     = '1;

      // Async reset with all inputs high: output clears without a clock.
      #2 rst = 1'b1;
      #1 chk("rst_async", y0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 chk("rst_hold", y0, 1'b0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 chk("rst_release", y0, 1'b1);

      apply("all_zero", '0);
      apply("all_one", '1);
      apply("all_zero_again", '0);

      v = '0;
      for (int i = 0; i < 63; i++) v[i] = 1'b1;
      apply("thr_63", v);
      v[63] = 1'b1;
      apply("thr_64", v);
      v[0] = 1'b0;
      apply("thr_63b", v);

      v = '0;
      for (int i = 63; i < 127; i++) v[i] = 1'b1;
      apply("pos_upper64", v);
      v = '0;
      for (int i = 0; i < 127; i += 2) v[i] = 1'b1;
      apply("pos_even64", v);
      apply("pos_rand63", rand_vec(63));
      apply("pos_rand64", rand_vec(64));
      v = '0;
      v[126] = 1'b1;
      apply("only_x126", v);

      // Reset pulsed between edges while a 1 is being held.
      v = rand_vec(100);
      apply("mid_pre", v);
      #2 rst = 1'b1;
      #1 chk("mid_async", y0, 1'b0);
      #1 rst = 1'b0;
      apply("mid_recover", v);

      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(3, 0) != 0) k = $urandom_range(68, 60);
         else k = $urandom_range(127, 0);
         apply("rand", rand_vec(k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
